pdp8_clk_ctl: RTL

Parametrised clock-enable and run-control generator for the PDP-8 core. It replaces free-running divider-bit clocks with single-cycle enable strobes, all in the master clock domain. It provides a fixed-rate display refresh strobe and a CPU clock enable with a runtime-programmable divisor. A RUN/HALT/STEP state machine gates the CPU enable, including single-instruction-cycle stepping from front-panel requests. It sits between the top level's crystal clock and the CPU and display logic.

---
 rtl/pdp8_clk_ctl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pdp8_clk_ctl.sv
// PDP-8 clock-enable and RUN/HALT/STEP run-control generator (single CLK domain).
// Optional macro PDP8_CLKCTL_SYNC_INPUTS_EN adds two-flop synchronizers on the request inputs.
module pdp8_clk_ctl #(
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = 2048
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [WIDTH-1:0] cpu_div,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  output logic             refresh_ce,
  output logic             cpu_ce,
  output logic             running,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RMAX = WIDTH'(REFRESH_DIV - 1);

  // request vector: [0]=run, [1]=halt, [2]=step
  logic [2:0] w_req;
  logic [2:0] w_req_s;
  assign w_req = {step_req, halt_req, run_req};

`ifdef PDP8_CLKCTL_SYNC_INPUTS_EN
  logic [2:0] r_sync1, r_sync2;
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_req;
      r_sync2 <= r_sync1;
    end
  end
  assign w_req_s = r_sync2;
`else
  assign w_req_s = w_req;
`endif

  // Register the request once, then compare against its previous value.
  logic [2:0] r_req_cur, r_req_prev;
  logic [2:0] w_edge;
  logic       w_run_e, w_halt_e, w_step_e;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_req_cur  <= '0;
      r_req_prev <= '0;
    end else begin
      r_req_cur  <= w_req_s;
      r_req_prev <= r_req_cur;
    end
  end

  assign w_edge   = r_req_cur & ~r_req_prev;
  assign w_run_e  = w_edge[0];
  assign w_halt_e = w_edge[1];
  assign w_step_e = w_edge[2];

  logic [WIDTH-1:0] r_rcnt;
  logic             w_refresh_tick;
  assign w_refresh_tick = (r_rcnt == RMAX);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_rcnt     <= '0;
      refresh_ce <= 1'b0;
    end else begin
      r_rcnt     <= w_refresh_tick ? '0 : r_rcnt + WIDTH'(1);
      refresh_ce <= w_refresh_tick;
    end
  end

  // Compare with >= so lowering cpu_div below ccnt ticks at once instead of wrapping.
  logic [WIDTH-1:0] r_ccnt;
  logic [WIDTH-1:0] w_d;
  logic             w_cpu_tick;
  assign w_d        = (cpu_div == '0) ? WIDTH'(1) : cpu_div;
  assign w_cpu_tick = (r_ccnt >= (w_d - WIDTH'(1)));

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) r_ccnt <= '0;
    else         r_ccnt <= w_cpu_tick ? '0 : r_ccnt + WIDTH'(1);
  end

  state_t r_state, w_next;
  logic   r_running;
  logic   w_ce_next;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= S_HALT;
      r_running <= 1'b0;
      cpu_ce    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_running <= (w_next == S_RUN);
      cpu_ce    <= w_ce_next;
    end
  end

  // Halt wins over run, run over step; a halt edge also kills a coincident strobe.
  always_comb begin
    w_next    = r_state;
    w_ce_next = w_cpu_tick & ((r_state == S_RUN) | (r_state == S_STEP)) & ~w_halt_e;
    unique case (r_state)
      S_HALT: begin
        if (!w_halt_e) begin
          if (w_run_e)       w_next = S_RUN;
          else if (w_step_e) w_next = S_STEP;
        end
      end
      S_RUN:   if (w_halt_e) w_next = S_HALT;
      S_STEP:  if (w_halt_e || w_cpu_tick) w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
  end

  assign state   = r_state;
  assign running = r_running;

endmodule
